ahb_param_arbiter: RTL

AHB_PARAM_ARBITER -- requirements
Module: ahb_param_arbiter

---
 rtl/ahb_param_arbiter_pkg.sv | 44 ++++
 rtl/ahb_param_arbiter_pick.sv | 47 ++++
 rtl/ahb_param_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ahb_param_arbiter_pkg.sv
// Shared AHB encodings, arbitration mode and FSM state types for the parameterised arbiter.
package AHB_package;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    BURST = 2'd2
  } arb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Beats in a burst; zero marks an undefined-length INCR.
  function automatic logic [4:0] beat_count(input logic [2:0] burst);
    logic [4:0] n;
    n = 5'd1;
    case (burst)
      HBURST_SINGLE:                n = 5'd1;
      HBURST_INCR:                  n = 5'd0;
      HBURST_WRAP4,  HBURST_INCR4:  n = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  n = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
      default:                      n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_param_arbiter_pick.sv
// Combinational winner selection: highest priority (lowest index on ties) or
// round-robin search starting just after the last owner.
module ahb_arb_pick
  import AHB_package::*;
#(
  parameter int NUM_MASTER = 4,
  parameter int PRIOR_W    = $clog2(NUM_MASTER)
) (
  input  logic [NUM_MASTER-1:0]         hreq,
  input  logic [NUM_MASTER*PRIOR_W-1:0] hprior,
  input  logic [$clog2(NUM_MASTER)-1:0] ptr,
  input  arb_mode_e                     mode,
  output logic [$clog2(NUM_MASTER)-1:0] winner,
  output logic                          valid
);

  localparam int MW = $clog2(NUM_MASTER);

  logic               take_s;
  logic [PRIOR_W-1:0] best_s;
  logic [MW-1:0]      idx_s;

  // Scan requesters and keep the first qualifying candidate
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    take_s = 1'b0;
    best_s = '0;
    idx_s  = '0;
    if (mode == ARB_FIXED) begin
      for (int i = 0; i < NUM_MASTER; i++) begin
        take_s = hreq[i] & (~valid | (hprior[i*PRIOR_W +: PRIOR_W] > best_s));
        winner = take_s ? MW'(i) : winner;
        best_s = take_s ? hprior[i*PRIOR_W +: PRIOR_W] : best_s;
        valid  = valid | take_s;
      end
    end else begin
      for (int k = 1; k <= NUM_MASTER; k++) begin
        idx_s  = MW'((int'(ptr) + k) % NUM_MASTER);
        take_s = hreq[idx_s] & ~valid;
        winner = take_s ? idx_s : winner;
        valid  = valid | take_s;
      end
    end
  end

endmodule

// File: rtl/ahb_param_arbiter.sv
// AHB bus arbiter: grants one master per transfer, holds the grant for whole
// bursts and re-arbitrates only at accepted beats that end a transfer.
module ahb_param_arbiter
  import AHB_package::*;
#(
  parameter int        NUM_MASTER = 4,
  parameter int        PRIOR_W    = $clog2(NUM_MASTER),
  parameter arb_mode_e ARB_MODE   = ARB_FIXED,
  parameter int        INCR_LIMIT = 16
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [NUM_MASTER-1:0]         hreq,
  input  logic [NUM_MASTER*PRIOR_W-1:0] hprior,
  input  logic [1:0]                    htrans,
  input  logic [2:0]                    hburst,
  input  logic                          hwait,
  output logic [NUM_MASTER-1:0]         hgrant,
  output logic [$clog2(NUM_MASTER)-1:0] hmaster,
  output logic [$clog2(NUM_MASTER)-1:0] hmaster_data,
  output logic                          hsel
);

  localparam int MW  = $clog2(NUM_MASTER);
  localparam int ICW = $clog2(INCR_LIMIT + 1);

  arb_state_e            state_r, state_s;
  logic [NUM_MASTER-1:0] hgrant_r;
  logic [MW-1:0]         hmaster_r, hmaster_data_r, rr_ptr_r;
  logic [4:0]            cnt_r, cnt_s, beats_s;
  logic [ICW-1:0]        incr_cnt_r, incr_cnt_s;
  logic                  unbounded_r, unbounded_s;
  logic [MW-1:0]         winner_s;
  logic                  winner_vld_s, accept_s, others_s, arb_pt_s, load_grant_s;

  ahb_arb_pick #(
    .NUM_MASTER(NUM_MASTER),
    .PRIOR_W   (PRIOR_W)
  ) u_pick (
    .hreq  (hreq),
    .hprior(hprior),
    .ptr   (rr_ptr_r),
    .mode  (ARB_MODE),
    .winner(winner_s),
    .valid (winner_vld_s)
  );

  assign accept_s = htrans[1] & ~hwait;
  assign others_s = |(hreq & ~hgrant_r);

  // Transfer tracking and arbitration-point detection
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    incr_cnt_s  = incr_cnt_r;
    unbounded_s = unbounded_r;
    arb_pt_s    = 1'b0;
    beats_s     = beat_count(hburst);
    case (state_r)
      IDLE: arb_pt_s = 1'b1;
      ADDR: begin
        if (accept_s && (htrans == HTRANS_NONSEQ)) begin
          if (beats_s == 5'd1) begin
            arb_pt_s = 1'b1;
          end else begin
            state_s     = BURST;
            unbounded_s = (beats_s == 5'd0);
            cnt_s       = (beats_s == 5'd0) ? 5'd0 : (beats_s - 5'd1);
            incr_cnt_s  = ICW'(1);
            arb_pt_s    = (beats_s == 5'd0) && (int'(incr_cnt_s) >= INCR_LIMIT) && others_s;
          end
        end else begin
          // IDLE (early termination) or a stray SEQ ends the slot; BUSY just waits
          arb_pt_s = ~hwait && (htrans != HTRANS_BUSY);
        end
      end
      BURST: begin
        if (accept_s && (htrans == HTRANS_SEQ)) begin
          if (unbounded_r) begin
            if (int'(incr_cnt_r) < INCR_LIMIT) begin
              incr_cnt_s = incr_cnt_r + ICW'(1);
            end else begin
              incr_cnt_s = incr_cnt_r;
            end
            arb_pt_s = (int'(incr_cnt_s) >= INCR_LIMIT) && others_s;
          end else begin
            cnt_s    = cnt_r - 5'd1;
            arb_pt_s = (cnt_r == 5'd1);
          end
        end else begin
          arb_pt_s = ~hwait && (htrans != HTRANS_BUSY);
        end
      end
      default: state_s = IDLE;
    endcase
    load_grant_s = arb_pt_s & ~hwait;
    if (load_grant_s) begin
      state_s     = winner_vld_s ? ADDR : IDLE;
      cnt_s       = 5'd0;
      incr_cnt_s  = '0;
      unbounded_s = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State, grant, ownership and round-robin pointer registers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r        <= IDLE;
      hgrant_r       <= '0;
      hmaster_r      <= '0;
      hmaster_data_r <= '0;
      rr_ptr_r       <= MW'(NUM_MASTER - 1);
      cnt_r          <= 5'd0;
      incr_cnt_r     <= '0;
      unbounded_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      incr_cnt_r  <= incr_cnt_s;
      unbounded_r <= unbounded_s;
      if (accept_s) begin
        hmaster_data_r <= hmaster_r;
      end
      if (load_grant_s) begin
        if (winner_vld_s) begin
          hgrant_r  <= NUM_MASTER'(1'b1) << winner_s;
          hmaster_r <= winner_s;
          rr_ptr_r  <= winner_s;
        end else begin
          hgrant_r <= '0;
        end
      end
    end
  end

  assign hgrant       = hgrant_r;
  assign hmaster      = hmaster_r;
  assign hmaster_data = hmaster_data_r;
  assign hsel         = (|hgrant_r) & htrans[1];

endmodule
